// File: rtl/hero_motion_ctrl.sv
// Per-frame hero sprite / background scroll sequencer for the VGA pixel selector.
// Optional macro WRAP_SCROLL_EN: scroll offsets wrap modulo MAP_MAX+1 instead of saturating.
module hero_motion_ctrl #(
  parameter int FRAME_DIV   = 30,
  parameter int HOLD_FRAMES = 8,
  parameter int SCROLL_STEP = 1,
  parameter int MAP_MAX     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] dir,
  output logic       pressed,
  output logic       anim_phase,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y
);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  localparam int ANIM_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(FRAME_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
  localparam logic [10:0] STEP11 = 11'(SCROLL_STEP);
  localparam logic [10:0] MAX11  = 11'(MAP_MAX);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        dir_d;
  logic              pressed_d, phase_d;
  logic [ANIM_W-1:0] anim_cnt, anim_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [9:0]        sx_d, sy_d;
  logic              any_btn;
  logic [1:0]        pri_dir;

  function automatic logic [9:0] step_dn(input logic [9:0] v);
    logic [10:0] w;
    w = {1'b0, v};
    if (w < STEP11) begin
`ifdef WRAP_SCROLL_EN
      return 10'(MAX11 + 11'd1 - (STEP11 - w));
`else
      return 10'd0;
`endif
    end
    return 10'(w - STEP11);
  endfunction

  function automatic logic [9:0] step_up(input logic [9:0] v);
    logic [10:0] sum;
    sum = {1'b0, v} + STEP11;
    if (sum > MAX11) begin
`ifdef WRAP_SCROLL_EN
      return 10'(sum - MAX11 - 11'd1);
`else
      return 10'(MAX11);
`endif
    end
    return 10'(sum);
  endfunction

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    if (btn_up)        pri_dir = DIR_UP;
    else if (btn_down) pri_dir = DIR_DOWN;
    else if (btn_left) pri_dir = DIR_LEFT;
    else               pri_dir = DIR_RIGHT;
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
    state_d   = state_q;
    dir_d     = dir;
    pressed_d = pressed;
    phase_d   = anim_phase;
    anim_d    = anim_cnt;
    hold_d    = hold_cnt;
    sx_d      = scroll_x;
    sy_d      = scroll_y;
    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (any_btn) begin
            state_d   = MOVE;
            dir_d     = pri_dir;
            pressed_d = 1'b1;
            anim_d    = '0;
          end else if (anim_cnt == ANIM_LAST) begin
            phase_d = ~anim_phase;
            anim_d  = '0;
          end else begin
            anim_d = anim_cnt + 1'b1;
          end
        end
        MOVE: begin
          if (any_btn) begin
            dir_d = pri_dir;
            unique case (pri_dir)
              DIR_UP:   sy_d = step_dn(scroll_y);
              DIR_DOWN: sy_d = step_up(scroll_y);
              DIR_LEFT: sx_d = step_dn(scroll_x);
              default:  sx_d = step_up(scroll_x);
            endcase
          end else if (HOLD_FRAMES == 0) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        HOLD: begin
          if (any_btn) begin
            state_d = MOVE;
            dir_d   = pri_dir;
          end else if (hold_cnt == '0) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            phase_d   = 1'b0;
            anim_d    = '0;
          end else begin
            hold_d = hold_cnt - 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dir        <= DIR_UP;
      pressed    <= 1'b0;
      anim_phase <= 1'b0;
      anim_cnt   <= '0;
      hold_cnt   <= '0;
      scroll_x   <= '0;
      scroll_y   <= '0;
    end else begin
      state_q    <= state_d;
      dir        <= dir_d;
      pressed    <= pressed_d;
      anim_phase <= phase_d;
      anim_cnt   <= anim_d;
      hold_cnt   <= hold_d;
      scroll_x   <= sx_d;
      scroll_y   <= sy_d;
    end
  end

endmodule

// File: tb/tb_hero_motion_ctrl.sv
// Directed, table-driven bench for hero_motion_ctrl with default parameters.
module tb_hero_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [1:0] dir;
  logic       pressed, anim_phase;
  logic [9:0] scroll_x, scroll_y;

  int n_tests = 0;
  int n_fail  = 0;

  hero_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .dir(dir), .pressed(pressed), .anim_phase(anim_phase),
    .scroll_x(scroll_x), .scroll_y(scroll_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [3:0] btn;     // {up, down, left, right}
    logic [1:0] dir;
    logic       pressed;
    logic       phase;
    logic [9:0] sx;
    logic [9:0] sy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic t, input logic [3:0] b, input logic [1:0] d,
                              input logic p, input logic ph, input logic [9:0] x, input logic [9:0] y);
    vec_t v;
    v.tick = t; v.btn = b; v.dir = d; v.pressed = p; v.phase = ph; v.sx = x; v.sy = y;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] d, input logic p, input logic ph,
                           input logic [9:0] x, input logic [9:0] y);
    check({tag, ".dir"}, 32'(dir), 32'(d));
    check({tag, ".pressed"}, 32'(pressed), 32'(p));
    check({tag, ".phase"}, 32'(anim_phase), 32'(ph));
    check({tag, ".sx"}, 32'(scroll_x), 32'(x));
    check({tag, ".sy"}, 32'(scroll_y), 32'(y));
  endtask

  // One clock cycle with the given buttons; frame_tick optional; sample 1 ns after the edge.
  task automatic apply(input logic t, input logic [3:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    frame_tick = t;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  logic [9:0] sx_a, sx_b, sx_c, sx_d;

  initial begin
`ifdef WRAP_SCROLL_EN
    sx_a = 10'd1023; sx_b = 10'd1022; sx_c = 10'd1023; sx_d = 10'd0;
`else
    sx_a = 10'd0;    sx_b = 10'd0;    sx_c = 10'd1;    sx_d = 10'd2;
`endif
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, 0, 0));     // entry tick, no scroll
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, 0, 1));
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, 0, 2));
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, 0, 3));
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, 0, 4));
    vecs.push_back(mk(1, 4'b0011, 2'b10, 1, 0, sx_a, 4));  // left beats right, at floor
    vecs.push_back(mk(1, 4'b0011, 2'b10, 1, 0, sx_b, 4));
    vecs.push_back(mk(1, 4'b1010, 2'b00, 1, 0, sx_b, 3));  // up beats left
    vecs.push_back(mk(1, 4'b0001, 2'b11, 1, 0, sx_c, 3));
    vecs.push_back(mk(1, 4'b0001, 2'b11, 1, 0, sx_d, 3));
    vecs.push_back(mk(1, 4'b0101, 2'b01, 1, 0, sx_d, 4));  // down beats right
    vecs.push_back(mk(0, 4'b1000, 2'b01, 1, 0, sx_d, 4));  // no tick: ignored
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 4'b0000, 2'b01, 1, 0, sx_d, 4)); // hold frames
    vecs.push_back(mk(1, 4'b0000, 2'b01, 0, 0, sx_d, 4));  // 9th release tick -> idle
    vecs.push_back(mk(0, 4'b0100, 2'b01, 0, 0, sx_d, 4));  // no tick: ignored
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, sx_d, 4));
    vecs.push_back(mk(1, 4'b0000, 2'b01, 1, 0, sx_d, 4));
    vecs.push_back(mk(1, 4'b0000, 2'b01, 1, 0, sx_d, 4));
    vecs.push_back(mk(1, 4'b1000, 2'b00, 1, 0, sx_d, 4));  // hold -> move, no scroll
    vecs.push_back(mk(1, 4'b1000, 2'b00, 1, 0, sx_d, 3));
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, sx_d, 4));
    vecs.push_back(mk(1, 4'b0100, 2'b01, 1, 0, sx_d, 5));

    #1 rst = 1'b1;
    #2;
    check_all("reset", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle animation: phase high after ticks 30..59, low again after tick 60.
    for (int k = 1; k <= 60; k++) begin
      apply(1'b1, 4'b0000);
      check($sformatf("idle%0d.phase", k), 32'(anim_phase), 32'((k >= 30 && k < 60) ? 1 : 0));
      if (k == 1 || k == 30 || k == 60)
        check_all($sformatf("idle%0d", k), 2'b00, 0, anim_phase, 0, 0);
    end

    foreach (vecs[i]) begin
      apply(vecs[i].tick, vecs[i].btn);
      check_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].pressed, vecs[i].phase,
                vecs[i].sx, vecs[i].sy);
    end

    // Reset coincident with a tick while moving: async clear, reset beats the tick.
    @(negedge clk);
    btn_down = 1'b1;
    frame_tick = 1'b1;
    rst = 1'b1;
    #1;
    check_all("rst_async", 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst_edge", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    btn_down = 1'b0;
    apply(1'b1, 4'b0000);
    check_all("post_rst", 2'b00, 0, 0, 0, 0);

    // Animation counter restarted from zero: toggle lands on the 30th idle tick.
    for (int k = 2; k <= 30; k++) begin
      apply(1'b1, 4'b0000);
      if (k == 29) check("post_rst29.phase", 32'(anim_phase), 32'd0);
      if (k == 30) check("post_rst30.phase", 32'(anim_phase), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
